// File: rtl/clock_gate_controller_pkg.sv
// Shared types and helpers for the multi-channel clock-gating controller.
package clock_gate_controller_pkg;

  // Per-channel gating state; encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } ch_state_e;

  // The counter holds both the wake delay and the idle hold-off,
  // so it must be wide enough for whichever is larger.
  function automatic int calc_cnt_w(input int idle_w, input int wake_cycles);
    int wake_w;
    wake_w = $clog2(wake_cycles + 1);
    return (idle_w > wake_w) ? idle_w : wake_w;
  endfunction

endpackage

// File: rtl/clock_gate_channel_fsm.sv
// One gated-clock channel: wake delay, on/drain tracking and output decode.
//
// Handshake: req is a level request. ack rises only once the gated clock
// is guaranteed running (wake delay elapsed) and stays high until the
// channel has fully drained back to off. Dropping req never aborts a wake;
// the channel reaches on and then drains normally. busy keeps an already
// running channel on but never wakes an off channel.
module clock_gate_channel_fsm
  import clock_gate_controller_pkg::*;
#(
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              busy,
  input  logic [IDLE_W-1:0] idle_count,
  input  logic              force_on,
  output logic              ack,
  output logic              gate_en,
  output ch_state_e         state
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset aborts any wake or drain at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (req) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ON: begin
        if (!req && !busy) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(idle_count);
        end
      end
      ST_DRAIN: begin
        // Renewed activity wins over expiry in the same cycle.
        if (req || busy) begin
          state_d = ST_ON;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only; force_on just holds the gate open.
  assign gate_en = (state_q != ST_OFF) | force_on;
  assign ack     = (state_q == ST_ON) | (state_q == ST_DRAIN);
  assign state   = state_q;

endmodule

// File: rtl/clock_gate_module.sv
// Glitch-free clock gate cell: the enable is captured while the source
// clock is low, so the gated clock only ever produces whole pulses.
module clock_gate_module (
  input  logic clk,
  input  logic en,
  output logic clk_out
);

  logic en_q;

  // Capture the enable on the falling edge so it is stable for the high phase.
  always_ff @(negedge clk) begin
    en_q <= en;
  end

  assign clk_out = clk & en_q;

endmodule

// File: rtl/clock_gate_controller.sv
// Multi-channel clock-gating controller: one channel FSM and one gate cell
// per channel, plus a global "any clock running" indication.
module clock_gate_controller
  import clock_gate_controller_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                CLK_IN,
  input  logic                RESET,
  input  logic [NUM_CH-1:0]   REQ,
  input  logic [NUM_CH-1:0]   BUSY,
  input  logic [IDLE_W-1:0]   IDLE_COUNT,
  input  logic                FORCE_ON,
  output logic [NUM_CH-1:0]   ACK,
  output logic [NUM_CH-1:0]   GATE_EN,
  output logic                ANY_ON,
  output logic [NUM_CH-1:0]   CLK_OUT,
  output logic [2*NUM_CH-1:0] DBG_STATE
);

  localparam int CNT_W = calc_cnt_w(IDLE_W, WAKE_CYCLES);

  // One independent FSM plus gate cell per channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e ch_state;

    clock_gate_channel_fsm #(
      .IDLE_W      (IDLE_W),
      .WAKE_CYCLES (WAKE_CYCLES),
      .CNT_W       (CNT_W)
    ) u_fsm (
      .clk        (CLK_IN),
      .rst        (RESET),
      .req        (REQ[i]),
      .busy       (BUSY[i]),
      .idle_count (IDLE_COUNT),
      .force_on   (FORCE_ON),
      .ack        (ACK[i]),
      .gate_en    (GATE_EN[i]),
      .state      (ch_state)
    );

    clock_gate_module u_gate (
      .clk     (CLK_IN),
      .en      (GATE_EN[i]),
      .clk_out (CLK_OUT[i])
    );

    assign DBG_STATE[2*i +: 2] = ch_state;
  end

  assign ANY_ON = |GATE_EN;

endmodule

// File: tb/tb_clock_gate_controller.sv
// Directed bench for clock_gate_controller (NUM_CH=4, WAKE_CYCLES=2).
module tb_clock_gate_controller;

  localparam int NUM_CH = 4;
  localparam int IDLE_W = 8;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_WAKE  = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic                CLK_IN;
  logic                RESET;
  logic [NUM_CH-1:0]   REQ;
  logic [NUM_CH-1:0]   BUSY;
  logic [IDLE_W-1:0]   IDLE_COUNT;
  logic                FORCE_ON;
  logic [NUM_CH-1:0]   ACK;
  logic [NUM_CH-1:0]   GATE_EN;
  logic                ANY_ON;
  logic [NUM_CH-1:0]   CLK_OUT;
  logic [2*NUM_CH-1:0] DBG_STATE;

  int tests_run;
  int tests_failed;
  int rise1, fall1, rise3;
  int base_r, base_f, gate_hi;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;

  clock_gate_controller #(
    .NUM_CH      (NUM_CH),
    .IDLE_W      (IDLE_W),
    .WAKE_CYCLES (2)
  ) dut (
    .CLK_IN     (CLK_IN),
    .RESET      (RESET),
    .REQ        (REQ),
    .BUSY       (BUSY),
    .IDLE_COUNT (IDLE_COUNT),
    .FORCE_ON   (FORCE_ON),
    .ACK        (ACK),
    .GATE_EN    (GATE_EN),
    .ANY_ON     (ANY_ON),
    .CLK_OUT    (CLK_OUT),
    .DBG_STATE  (DBG_STATE)
  );

  // Clock: rising edges at 5, 15, 25 ...
  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  // Gated-clock pulse counters used to spot missing or partial pulses.
  initial begin
    rise1 = 0;
    fall1 = 0;
    rise3 = 0;
  end
  always @(posedge CLK_OUT[1]) rise1++;
  always @(negedge CLK_OUT[1]) fall1++;
  always @(posedge CLK_OUT[3]) rise3++;

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] st(input int ch);
    return DBG_STATE[2*ch +: 2];
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RESET      = 1'b1;
    REQ        = '0;
    BUSY       = '0;
    IDLE_COUNT = 8'd3;
    FORCE_ON   = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_gate",  32'(GATE_EN),   32'h0);
    check("rst_ack",   32'(ACK),       32'h0);
    check("rst_any",   32'(ANY_ON),    32'h0);
    check("rst_clk",   32'(CLK_OUT),   32'h0);
    check("rst_state", 32'(DBG_STATE), 32'h0);
    RESET = 1'b0;
    repeat (2) tick();

    // Wake latency on channel 0
    REQ[0] = 1'b1;
    tick();
    check("wake_gate_n",   32'(GATE_EN), 32'b0001);
    check("wake_clk_n",    32'(CLK_OUT), 32'b0000);
    check("wake_state_n",  32'(st(0)),   32'(S_WAKE));
    check("wake_ack_n",    32'(ACK),     32'h0);
    tick();
    check("wake_clk_n1",   32'(CLK_OUT), 32'b0001);
    check("wake_ack_n1",   32'(ACK),     32'h0);
    tick();
    check("wake_ack_n2",   32'(ACK),     32'b0001);
    check("wake_state_n2", 32'(st(0)),   32'(S_ON));

    // Drain with IDLE_COUNT=3 on channel 1
    REQ[1]  = 1'b1;
    BUSY[1] = 1'b1;
    repeat (3) tick();
    check("drain_ack_on", 32'(ACK[1]), 32'h1);
    REQ[1]  = 1'b0;
    BUSY[1] = 1'b0;
    base_r  = rise1;
    base_f  = fall1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      check($sformatf("drain_gate_k%0d", k), 32'(GATE_EN[1]), (k < 4) ? 32'h1 : 32'h0);
      check($sformatf("drain_ack_k%0d", k),  32'(ACK[1]),     (k < 4) ? 32'h1 : 32'h0);
      if (k == 0) check("drain_state_entry", 32'(st(1)), 32'(S_DRAIN));
    end
    repeat (2) tick();
    check("drain_rises", 32'(rise1 - base_r), 32'd5);
    check("drain_falls", 32'(fall1 - base_f), 32'd6);

    // BUSY pulse at drain expiry on channel 2 restarts the hold-off
    REQ[2] = 1'b1;
    repeat (3) tick();
    check("rearm_ack_on", 32'(ACK[2]), 32'h1);
    REQ[2] = 1'b0;
    repeat (4) tick();
    check("rearm_state_cnt0", 32'(st(2)), 32'(S_DRAIN));
    BUSY[2] = 1'b1;
    tick();
    check("rearm_state_on", 32'(st(2)), 32'(S_ON));
    check("rearm_ack_on2",  32'(ACK[2]), 32'h1);
    BUSY[2] = 1'b0;
    tick();
    check("rearm_state_drain", 32'(st(2)), 32'(S_DRAIN));
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("rearm_ack_k%0d", k), 32'(ACK[2]), (k < 4) ? 32'h1 : 32'h0);
    end

    // IDLE_COUNT=0 with a one-cycle REQ pulse on channel 3
    IDLE_COUNT = 8'd0;
    exp_q.push_back({S_WAKE,  1'b0, 1'b1});
    exp_q.push_back({S_WAKE,  1'b0, 1'b1});
    exp_q.push_back({S_ON,    1'b1, 1'b1});
    exp_q.push_back({S_DRAIN, 1'b1, 1'b1});
    exp_q.push_back({S_OFF,   1'b0, 1'b0});
    gate_hi = 0;
    REQ[3] = 1'b1;
    tick();
    REQ[3] = 1'b0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check("pulse_seq", 32'({st(3), ACK[3], GATE_EN[3]}), 32'(exp_v));
      if (GATE_EN[3]) gate_hi++;
      if (exp_q.size() > 0) tick();
    end
    check("pulse_gate_cycles", 32'(gate_hi), 32'd4);

    // All channels idle
    REQ[0] = 1'b0;
    repeat (4) tick();
    check("idle_gate", 32'(GATE_EN), 32'h0);
    check("idle_any",  32'(ANY_ON),  32'h0);
    check("idle_ack",  32'(ACK),     32'h0);
    tick();
    check("idle_clk",  32'(CLK_OUT), 32'h0);

    // FORCE_ON through reset and idle
    FORCE_ON = 1'b1;
    RESET    = 1'b1;
    tick();
    check("force_rst_gate", 32'(GATE_EN), 32'hF);
    check("force_rst_any",  32'(ANY_ON),  32'h1);
    check("force_rst_ack",  32'(ACK),     32'h0);
    tick();
    check("force_rst_clk",  32'(CLK_OUT), 32'hF);
    RESET  = 1'b0;
    base_r = rise3;
    repeat (3) tick();
    check("force_rises",  32'(rise3 - base_r), 32'd3);
    check("force_ack",    32'(ACK),            32'h0);
    check("force_state",  32'(DBG_STATE),      32'h0);
    FORCE_ON = 1'b0;
    tick();
    check("unforce_gate", 32'(GATE_EN), 32'h0);
    check("unforce_clk",  32'(CLK_OUT), 32'h0);
    check("unforce_any",  32'(ANY_ON),  32'h0);

    // Reset mid-WAKE on all channels
    IDLE_COUNT = 8'd3;
    REQ = 4'hF;
    tick();
    check("midwake_gate",  32'(GATE_EN),   32'hF);
    check("midwake_ack",   32'(ACK),       32'h0);
    check("midwake_state", 32'(DBG_STATE), 32'h55);
    RESET = 1'b1;
    REQ   = 4'h0;
    tick();
    check("abort_gate",  32'(GATE_EN),   32'h0);
    check("abort_ack",   32'(ACK),       32'h0);
    check("abort_state", 32'(DBG_STATE), 32'h0);
    tick();
    check("abort_clk",   32'(CLK_OUT),   32'h0);
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort_ack_k%0d", k), 32'(ACK), 32'h0);
    end
    // A fresh wake must take the full delay again
    REQ = 4'b0001;
    tick();
    tick();
    check("rewake_ack_n1", 32'(ACK), 32'h0);
    tick();
    check("rewake_ack_n2", 32'(ACK), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clock_gate_controller.md
Name: clock_gate_controller

Overview:
- Parametrised multi-channel clock-gating controller; successor to the single-enable clock_gate_module.
- Per channel, a request/acknowledge handshake wakes a gated clock. A programmable idle hold-off then gates the clock off automatically.
- Sits between subsystem power/activity logic and the clock tree. Each channel drives one clock_gate_module instance, which does the glitch-free falling-edge enable latching.
- Global test override forces every gated clock on.

Parameters:
- NUM_CH, 4: number of independent gated clock channels (min 1).
- IDLE_W, 8: width of the idle hold-off threshold input.
- WAKE_CYCLES, 2: CLK_IN cycles from request sample to ACK (min 1). Covers clock-tree settle.
- CNT_W, max(IDLE_W, clog2(WAKE_CYCLES+1)): per-channel counter width (derived; not overridden).

Ports:
- CLK_IN  input  1  free-running source clock; all state on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  NUM_CH  per-channel clock request (level).
- BUSY  input  NUM_CH  per-channel activity; holds clock on while high after REQ drops.
- IDLE_COUNT  input  IDLE_W  idle hold-off threshold, shared by all channels.
- FORCE_ON  input  1  test/debug override; all CLK_OUT run.
- ACK  output  NUM_CH  per-channel: gated clock is guaranteed running.
- GATE_EN  output  NUM_CH  registered enable presented to each gate cell.
- ANY_ON  output  1  OR of GATE_EN.
- CLK_OUT  output  NUM_CH  gated clocks.

Behaviour:
- Interface (already decided): one clock, CLK_IN; reset RESET is synchronous and active-high.
- Per-channel Moore FSM with states OFF, WAKE, ON, DRAIN and one counter cnt[CNT_W].
- OFF
  - REQ=1 -> WAKE; cnt <= WAKE_CYCLES-1.
  - BUSY alone does not wake a channel.
- WAKE
  - cnt==0 -> ON; otherwise cnt decrements.
  - REQ dropping during WAKE does not abort; the channel reaches ON, then drains normally.
- ON
  - REQ=0 and BUSY=0 -> DRAIN; cnt <= IDLE_COUNT.
  - IDLE_COUNT is sampled only at DRAIN entry.
- DRAIN
  - REQ|BUSY -> ON. This has priority over expiry in the same cycle.
  - Otherwise cnt==0 -> OFF; else cnt decrements.
- Outputs by state
  - GATE_EN = (state != OFF) | FORCE_ON.
  - ACK = state is ON or DRAIN.
  - All outputs are registered or decoded from registered state; no combinational path from REQ to outputs.
- Latency
  - REQ sampled high at edge n -> GATE_EN high after edge n.
  - First CLK_OUT rising edge at edge n+1 (gate cell latches on the falling edge).
  - ACK high after edge n+WAKE_CYCLES.
- Drain timing
  - DRAIN entered at edge m -> OFF, GATE_EN low and ACK low after edge m+IDLE_COUNT+1.
  - IDLE_COUNT=0 gives a single-cycle DRAIN.
- FORCE_ON
  - Affects only GATE_EN.
  - FSMs, ACK and counters run unchanged. Deasserting FORCE_ON reverts GATE_EN to FSM state on the next cycle.
- Reset
  - All channels go to OFF, cnt=0, ACK=0, GATE_EN=FORCE_ON, ANY_ON=FORCE_ON.
  - Reset mid-WAKE or mid-DRAIN aborts immediately. The gate cell closes on the next falling edge with no runt pulse.
- Channels are fully independent; simultaneous requests on all channels are legal.

Decomposition:
- Shared package
  - state enum (OFF=2'd0, WAKE=2'd1, ON=2'd2, DRAIN=2'd3).
  - CNT_W derivation function.
- Sub-module clock_gate_channel_fsm: one FSM, counter and ACK/GATE_EN decode per channel.
- Top level: generate loop over NUM_CH instantiating clock_gate_channel_fsm plus clock_gate_module, and the ANY_ON reduction.

Test Plan:
- Reset release, then REQ[0] high at edge 10, WAKE_CYCLES=2 -> GATE_EN[0] high after edge 10, first CLK_OUT[0] edge at 11, ACK[0] high after edge 12. Other channels stay OFF with CLK_OUT low.
- IDLE_COUNT=3: REQ[1] and BUSY[1] both drop at edge 20 while ON -> DRAIN at 20, GATE_EN[1] and ACK[1] low after edge 24; CLK_OUT[1] has no partial pulse.
- In DRAIN with cnt==0, BUSY[2] pulses for one cycle -> channel returns to ON, ACK stays high. After BUSY drops, a fresh IDLE_COUNT drain restarts.
- IDLE_COUNT=0, REQ pulses one cycle -> sequence OFF, WAKE, WAKE, ON, DRAIN, OFF; total GATE_EN high time = 4 cycles.
- FORCE_ON=1 during reset and idle -> all CLK_OUT toggle and ANY_ON=1, while ACK stays 0. Deassert -> clocks stop next cycle.
- RESET asserted mid-WAKE on all 4 channels -> ACK never rises; GATE_EN=0 after the reset edge; counters return to 0.
